pipe_hazard_unit: RTL and testbench

- Parametrised hazard, forwarding and pipeline-control unit for the in-order pipelined core.
- Generalises the fixed EX/MEM/WB forwarding, load-use stall and flush logic to an arbitrary number of post-decode stages, source operands and load-result latency.
- Adds a global external freeze.
- Sits beside the ID stage: tracks destination tags of in-flight instructions and drives PC/IF-ID enables, bubble insertion, IF/ID flush and per-operand EX forwarding selects.

---
 rtl/pipe_hazard_unit.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use hazard detection, EX operand forwarding selects and
// pipeline enable/flush/bubble control for an in-order core with DEPTH tracked
// post-decode stages (0=EX ... DEPTH-1=WB).
// Optional performance counters are built only when HAZARD_PERF_EN is defined;
// otherwise the counter ports are tied to zero.
module pipe_hazard_unit #(
    parameter int  RADDR_W    = 5,
    parameter int  NSRC       = 2,
    parameter int  DEPTH      = 3,
    parameter int  LOAD_STAGE = 2,
    parameter int  CNT_W      = 32,
    localparam int SELW       = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [NSRC*RADDR_W-1:0] id_src_addr,
    input  logic [NSRC-1:0]         id_src_used,
    input  logic [RADDR_W-1:0]      id_dst_addr,
    input  logic                    id_dst_we,
    input  logic                    id_is_load,
    input  logic                    id_jump,
    input  logic                    redirect,
    input  logic                    stall_ext,
    output logic                    pipe_en,
    output logic                    pc_we,
    output logic                    ifid_we,
    output logic                    ifid_flush,
    output logic                    idex_bubble,
    output logic [NSRC*SELW-1:0]    fwd_sel,
    output logic [CNT_W-1:0]        perf_stall_cnt,
    output logic [CNT_W-1:0]        perf_flush_cnt,
    output logic [CNT_W-1:0]        perf_fwd_cnt
);

    // Per-stage destination tags of in-flight instructions
    logic [DEPTH-1:0]        st_valid;
    logic [DEPTH-1:0]        st_we;
    logic [DEPTH-1:0]        st_load;
    logic [RADDR_W-1:0]      st_dst [DEPTH];
    // Source operands of the instruction currently in EX
    logic [NSRC*RADDR_W-1:0] ex_src;
    logic [NSRC-1:0]         ex_used;

    logic hazard;
    logic stall;

    // Load-use hazard: an ID operand depends on a load whose data is not yet forwardable
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (id_src_used[i] && st_valid[k] && st_we[k] && st_load[k]
                    && (st_dst[k] == id_src_addr[i*RADDR_W +: RADDR_W])
                    && (id_src_addr[i*RADDR_W +: RADDR_W] != '0)
                    && (k + 1 < LOAD_STAGE)) begin
                    hazard = 1'b1;
                end
            end
        end
        hazard = hazard & id_valid;
    end

    // Forward select per EX operand: scan oldest to youngest so the youngest producer wins
    always_comb begin
        fwd_sel = '0;
        if (!reset) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
                    if (ex_used[i] && st_valid[k] && st_we[k]
                        && (st_dst[k] == ex_src[i*RADDR_W +: RADDR_W])
                        && (ex_src[i*RADDR_W +: RADDR_W] != '0)) begin
                        fwd_sel[i*SELW +: SELW] = SELW'(k);
                    end
                end
            end
        end
    end

    // Pipeline control; a freeze masks everything, redirect overrides a load-use stall
    always_comb begin
        stall = hazard & ~redirect & ~stall_ext;
        if (reset) begin
            pipe_en     = 1'b1;
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
        end else if (stall_ext) begin
            pipe_en     = 1'b0;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end else begin
            pipe_en     = 1'b1;
            pc_we       = ~stall;
            ifid_we     = ~stall;
            ifid_flush  = redirect | (id_jump & id_valid & ~stall);
            idex_bubble = stall | redirect | ~id_valid;
        end
    end

    // Tag shift register: advance when the pipeline moves, insert ID or a bubble at EX
    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid <= '0;
            ex_used  <= '0;
        end else if (pipe_en) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_we[k]    <= st_we[k-1];
                st_load[k]  <= st_load[k-1];
                st_dst[k]   <= st_dst[k-1];
            end
            st_valid[0] <= ~idex_bubble;
            st_we[0]    <= id_dst_we;
            st_load[0]  <= id_is_load;
            st_dst[0]   <= id_dst_addr;
            ex_src      <= id_src_addr;
            // Bubbles carry no operand reads so they can never request forwarding
            ex_used     <= idex_bubble ? '0 : id_src_used;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (pipe_en && (|fwd_sel) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
    assign perf_fwd_cnt   = fwd_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
    assign perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: drives a default instance (DEPTH=3, LOAD_STAGE=2) and a
// deep instance (DEPTH=5, LOAD_STAGE=3) with the same ID stream, checks both
// against an in-flight-instruction model every cycle, plus directed literal cases.
// Counter expectations follow HAZARD_PERF_EN.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dst_addr;
    logic        id_dst_we;
    logic        id_is_load;
    logic        id_jump;
    logic        redirect;
    logic        stall_ext;

    logic        pe0, pc0, iw0, fl0, bb0;
    logic [3:0]  fw0;
    logic [31:0] cs0, cf0, cw0;
    logic        pe1, pc1, iw1, fl1, bb1;
    logic [5:0]  fw1;
    logic [31:0] cs1, cf1, cw1;

    int checks = 0;
    int errors = 0;

    pipe_hazard_unit u_d0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .id_is_load(id_is_load), .id_jump(id_jump), .redirect(redirect),
        .stall_ext(stall_ext), .pipe_en(pe0), .pc_we(pc0), .ifid_we(iw0),
        .ifid_flush(fl0), .idex_bubble(bb0), .fwd_sel(fw0),
        .perf_stall_cnt(cs0), .perf_flush_cnt(cf0), .perf_fwd_cnt(cw0)
    );

    pipe_hazard_unit #(.DEPTH(5), .LOAD_STAGE(3)) u_d1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .id_is_load(id_is_load), .id_jump(id_jump), .redirect(redirect),
        .stall_ext(stall_ext), .pipe_en(pe1), .pc_we(pc1), .ifid_we(iw1),
        .ifid_flush(fl1), .idex_bubble(bb1), .fwd_sel(fw1),
        .perf_stall_cnt(cs1), .perf_flush_cnt(cf1), .perf_fwd_cnt(cw1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each model keeps a list of in-flight instructions indexed by age since issue.
    typedef struct packed {
        bit       v;
        bit       we;
        bit       ld;
        bit [4:0] dst;
        bit [9:0] src;
        bit [1:0] used;
    } ent_t;

    ent_t        inflight [2][8];
    int unsigned mc_stall [2];
    int unsigned mc_flush [2];
    int unsigned mc_fwd   [2];
    bit          model_ok = 1'b0;

    int          dd, ls;
    int          fsel [2];
    bit          hz, stl, e_pe, e_pc, e_iw, e_fl, e_bb;
    logic [5:0]  e_fw;
    logic [31:0] e_cs, e_cf, e_cw;

    function automatic bit writes(input ent_t e, input bit [4:0] a);
        return e.v && e.we && (e.dst == a) && (a != 5'd0);
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            dd = (m == 0) ? 3 : 5;
            ls = (m == 0) ? 2 : 3;
            hz = 1'b0;
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < dd; k++)
                    if (id_src_used[i] && inflight[m][k].ld && (k + 1 < ls)
                        && writes(inflight[m][k], id_src_addr[i*5 +: 5]))
                        hz = 1'b1;
            hz  = hz && id_valid;
            stl = hz && !redirect && !stall_ext;
            for (int i = 0; i < 2; i++) begin
                fsel[i] = 0;
                if (!reset && inflight[m][0].used[i])
                    for (int k = dd - 1; k >= 1; k--)
                        if (writes(inflight[m][k], inflight[m][0].src[i*5 +: 5]))
                            fsel[i] = k;
            end
            if (reset) begin
                {e_pe, e_pc, e_iw, e_fl, e_bb} = 5'b11101;
            end else if (stall_ext) begin
                {e_pe, e_pc, e_iw, e_fl, e_bb} = 5'b00000;
            end else begin
                e_pe = 1'b1;
                e_pc = !stl;
                e_iw = !stl;
                e_fl = redirect || (id_jump && id_valid && !stl);
                e_bb = stl || redirect || !id_valid;
            end
            e_fw = (m == 0) ? {2'b00, 2'(fsel[1]), 2'(fsel[0])} : {3'(fsel[1]), 3'(fsel[0])};
`ifdef HAZARD_PERF_EN
            e_cs = mc_stall[m];
            e_cf = mc_flush[m];
            e_cw = mc_fwd[m];
`else
            e_cs = '0;
            e_cf = '0;
            e_cw = '0;
`endif
            if (model_ok) begin
                chk($sformatf("ctl_d%0d", m), (m == 0) ? {pe0, pc0, iw0, fl0, bb0} : {pe1, pc1, iw1, fl1, bb1},
                    {e_pe, e_pc, e_iw, e_fl, e_bb});
                chk($sformatf("fwd_d%0d", m), (m == 0) ? {2'b00, fw0} : fw1, e_fw);
                chk($sformatf("stall_cnt_d%0d", m), (m == 0) ? cs0 : cs1, e_cs);
                chk($sformatf("flush_cnt_d%0d", m), (m == 0) ? cf0 : cf1, e_cf);
                chk($sformatf("fwd_cnt_d%0d", m), (m == 0) ? cw0 : cw1, e_cw);
            end
            if (reset) begin
                for (int k = 0; k < 8; k++) inflight[m][k] = '0;
                mc_stall[m] = 0;
                mc_flush[m] = 0;
                mc_fwd[m]   = 0;
            end else begin
                mc_stall[m] += 32'(stl);
                mc_flush[m] += 32'(e_fl);
                mc_fwd[m]   += 32'(e_pe && (fsel[0] != 0 || fsel[1] != 0));
                if (!stall_ext) begin
                    for (int k = dd - 1; k >= 1; k--) inflight[m][k] = inflight[m][k-1];
                    inflight[m][0].v    = !e_bb;
                    inflight[m][0].we   = id_dst_we;
                    inflight[m][0].ld   = id_is_load;
                    inflight[m][0].dst  = id_dst_addr;
                    inflight[m][0].src  = id_src_addr;
                    inflight[m][0].used = e_bb ? 2'b00 : id_src_used;
                end
            end
        end
        if (reset) model_ok = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic [4:0] d, input logic we, input logic ld,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] u,
                       input logic j, input logic rd, input logic sx, input logic rs);
        @(posedge clk);
        #1;
        id_valid    = v;
        id_dst_addr = d;
        id_dst_we   = we;
        id_is_load  = ld;
        id_src_addr = {s1, s0};
        id_src_used = u;
        id_jump     = j;
        redirect    = rd;
        stall_ext   = sx;
        reset       = rs;
        @(negedge clk);
        #1;
    endtask

    task automatic ins(input logic [4:0] d, input logic ld, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [1:0] u);
        cyc(1'b1, d, 1'b1, ld, s0, s1, u, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nops(input int n);
        repeat (n) cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] f_before, s_before;

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_src_addr = '0; id_src_used = '0;
        id_dst_addr = '0; id_dst_we = 1'b0; id_is_load = 1'b0; id_jump = 1'b0;
        redirect = 1'b0; stall_ext = 1'b0;
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_ctl", {pe0, pc0, iw0, fl0, bb0}, 5'b11101);
        chk("reset_fwd", fw0, 4'd0);
        chk("reset_cnt", cs0 | cf0 | cw0, 32'd0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset_over_freeze", {pe1, pc1, iw1, fl1, bb1}, 5'b11101);
        nops(6);

        // lw $8 ; add $9,$8,$1 held in ID until both instances have issued it
        ins(5'd8, 1'b1, 5'd0, 5'd0, 2'b00);
        ins(5'd9, 1'b0, 5'd8, 5'd1, 2'b11);
        chk("lu_stall_d0", {pc0, iw0, bb0}, 3'b001);
        chk("lu_stall_d1", pc1, 1'b0);
        ins(5'd9, 1'b0, 5'd8, 5'd1, 2'b11);
        chk("lu_release_d0", pc0, 1'b1);
        chk("lu_stall2_d1", pc1, 1'b0);
        ins(5'd9, 1'b0, 5'd8, 5'd1, 2'b11);
        chk("lu_fwd_d0", fw0, 4'b0010);
        chk("lu_release_d1", pc1, 1'b1);
        nops(1);
        chk("lu_fwd_d1", fw1, 6'b000011);
        nops(6);

        // add $3,$1,$2 ; sub $4,$3,$3 with 0, 1 and 2 independent instructions between
        ins(5'd3, 1'b0, 5'd1, 5'd2, 2'b11);
        ins(5'd4, 1'b0, 5'd3, 5'd3, 2'b11);
        chk("raw0_nostall", pc0, 1'b1);
        nops(1);
        chk("raw0_fwd_d0", fw0, 4'b0101);
        chk("raw0_fwd_d1", fw1, 6'b001001);
        nops(6);
        ins(5'd3, 1'b0, 5'd1, 5'd2, 2'b11);
        ins(5'd10, 1'b0, 5'd11, 5'd12, 2'b11);
        ins(5'd4, 1'b0, 5'd3, 5'd3, 2'b11);
        nops(1);
        chk("raw1_fwd_d0", fw0, 4'b1010);
        chk("raw1_fwd_d1", fw1, 6'b010010);
        nops(6);
        ins(5'd3, 1'b0, 5'd1, 5'd2, 2'b11);
        ins(5'd10, 1'b0, 5'd11, 5'd12, 2'b11);
        ins(5'd10, 1'b0, 5'd11, 5'd12, 2'b11);
        ins(5'd4, 1'b0, 5'd3, 5'd3, 2'b11);
        nops(1);
        chk("raw2_fwd_d0", fw0, 4'b0000);
        chk("raw2_fwd_d1", fw1, 6'b011011);
        nops(6);

        // register 0 never matches, even for a load
        ins(5'd0, 1'b1, 5'd0, 5'd0, 2'b00);
        ins(5'd5, 1'b0, 5'd0, 5'd0, 2'b11);
        chk("r0_nostall", {pc0, pc1}, 2'b11);
        nops(1);
        chk("r0_fwd", {fw1, fw0}, 10'd0);
        nops(6);

        // unconditional jump flushes IF/ID without a bubble
        cyc(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jump_ctl", {pc0, fl0, bb0}, 3'b110);
        nops(6);

        // redirect wins over a load-use hazard
        ins(5'd8, 1'b1, 5'd0, 5'd0, 2'b00);
        cyc(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 5'd1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("redir_ctl", {pc0, fl0, bb0}, 3'b111);
        f_before = cf0;
        s_before = cs0;
        nops(1);
`ifdef HAZARD_PERF_EN
        chk("redir_flush_cnt", cf0, f_before + 32'd1);
        chk("redir_stall_cnt", cs0, s_before);
`else
        chk("redir_flush_cnt", cf0, 32'd0);
        chk("redir_stall_cnt", cs0, 32'd0);
`endif
        nops(6);

        // freeze held three cycles during a load-use stall
        ins(5'd8, 1'b1, 5'd0, 5'd0, 2'b00);
        repeat (3) begin
            cyc(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 5'd1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("freeze_ctl", {pe0, pc0, iw0, pe1, pc1, iw1}, 6'd0);
        end
        ins(5'd9, 1'b0, 5'd8, 5'd1, 2'b11);
        chk("frz_stall", {pc0, pc1}, 2'b00);
        ins(5'd9, 1'b0, 5'd8, 5'd1, 2'b11);
        chk("frz_release", {pc0, pc1}, 2'b10);
        ins(5'd9, 1'b0, 5'd8, 5'd1, 2'b11);
        chk("frz_fwd_d0", fw0, 4'b0010);
        nops(1);
        chk("frz_fwd_d1", fw1, 6'b000011);
        nops(6);

        // reset during a load-use stall
        ins(5'd8, 1'b1, 5'd0, 5'd0, 2'b00);
        cyc(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 5'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_stall_ctl", {pe0, pc0, iw0, fl0, bb0}, 5'b11101);
        chk("rst_stall_fwd", fw0, 4'd0);
        ins(5'd9, 1'b0, 5'd8, 5'd1, 2'b11);
        chk("rst_after_nostall", {pc0, pc1}, 2'b11);
        chk("rst_after_fwd", {fw1, fw0}, 10'd0);
        chk("rst_after_cnt", {cs0, cf0, cw0, cs1, cf1, cw1}, 192'd0);
        nops(6);

        // randomized stream on a small register set to provoke dependencies
        repeat (3000) begin
            cyc($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0);
        end

        nops(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
